// File: rtl/msgmii_rxsfd_align_pkg.sv
// msgmii_rxsfd_align_pkg: shared constants and types for the M-SGMII
// receive SFD aligner (state encoding, speed codes, preamble symbols).
package msgmii_rxsfd_align_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRE,
      ST_DATA,
      ST_DROP
   } rxsfd_st_e;

   localparam logic [1:0] SPEED_10   = 2'b00;
   localparam logic [1:0] SPEED_100  = 2'b01;
   localparam logic [1:0] SPEED_1000 = 2'b10;

   localparam logic [7:0] PRE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE = 8'hD5;
   localparam logic [3:0] PRE_NBL  = 4'h5;
   localparam logic [3:0] SFD_NBL  = 4'hD;

   localparam logic [4:0] MAX_PRE_GMII = 5'd15;
   localparam logic [4:0] MAX_PRE_MII  = 5'd30;

   // Only 1000 Mb/s runs byte-wide; every other code is nibble-wide MII.
   function automatic logic is_gmii(input logic [1:0] spd);
      return spd == SPEED_1000;
   endfunction

   // Compare the current symbol against a byte (GMII) or nibble (MII) value.
   function automatic logic is_sym(
      input logic [1:0] spd,
      input logic [7:0] d,
      input logic [7:0] b,
      input logic [3:0] n
   );
      return is_gmii(spd) ? (d == b) : (d[3:0] == n);
   endfunction

endpackage

// File: rtl/msgmii_rxnbl_asm.sv
// msgmii_rxnbl_asm: nibble phase tracking and byte assembly for MII;
// straight byte passthrough for GMII. byte_done is combinational.
module msgmii_rxnbl_asm
   import msgmii_rxsfd_align_pkg::*;
(
   input  logic       rx_clki,
   input  logic       rx_clkirst,
   input  logic       rxcen,
   input  logic [1:0] speed,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] rxd,
   output logic [7:0] byte_o,
   output logic       byte_done,
   output logic       nbl_pend
);

   logic       phase_q, phase_d;
   logic [3:0] lo_q, lo_d;

   // Low nibble is parked first; the byte completes on the high nibble.
   always_comb begin
      phase_d   = phase_q;
      lo_d      = lo_q;
      byte_o    = rxd;
      byte_done = 1'b0;
      if (clr) begin
         phase_d = 1'b0;
      end else if (en) begin
         if (is_gmii(speed)) begin
            byte_done = 1'b1;
         end else if (!phase_q) begin
            phase_d = 1'b1;
            lo_d    = rxd[3:0];
         end else begin
            phase_d   = 1'b0;
            byte_done = 1'b1;
            byte_o    = {rxd[3:0], lo_q};
         end
      end
   end

   assign nbl_pend = phase_q;

   // Phase and parked nibble advance only on enabled edges.
   always_ff @(posedge rx_clki or posedge rx_clkirst) begin
      if (rx_clkirst) begin
         phase_q <= 1'b0;
         lo_q    <= 4'h0;
      end else if (rxcen) begin
         phase_q <= phase_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: rtl/msgmii_rxsfd_align.sv
// msgmii_rxsfd_align: strips preamble/SFD from the G/MII receive stream and
// emits framed bytes. Optional preamble checking: MSGMII_RXSFD_PREMCHK_EN.
module msgmii_rxsfd_align
   import msgmii_rxsfd_align_pkg::*;
(
   input  logic       rx_clki,
   input  logic       rx_clkirst,
   input  logic       rxcen,
   input  logic [1:0] msgmii_speed,
   input  logic [7:0] rxd,
   input  logic       rx_dv,
   input  logic       rx_er,
   output logic [7:0] frm_data,
   output logic       frm_vld,
   output logic       frm_sof,
   output logic       frm_eof,
   output logic       frm_err,
   output logic       frm_drbl,
   output logic       frm_drop
);

   rxsfd_st_e  st_q, st_d;
   logic [1:0] speed_q, speed_d;

   logic [7:0] rxd_q, rxd_d;
   logic       dv_q, dv_d;
   logic       dv_prev_q, dv_prev_d;
   logic       er_q, er_d;

   logic [7:0] hold_q, hold_d;
   logic       hold_vld_q, hold_vld_d;
   logic       sof_pend_q, sof_pend_d;
   logic       err_q, err_d;

   logic [7:0] data_q, data_d;
   logic       vld_q, vld_d;
   logic       sof_q, sof_d;
   logic       eof_q, eof_d;
   logic       ferr_q, ferr_d;
   logic       drbl_q, drbl_d;
   logic       drop_q, drop_d;

`ifdef MSGMII_RXSFD_PREMCHK_EN
   logic [4:0] pcnt_q, pcnt_d;
   logic [4:0] pre_max;
   assign pre_max = is_gmii(speed_q) ? MAX_PRE_GMII : MAX_PRE_MII;
`endif

   logic       asm_clr, asm_en, asm_done, asm_pend;
   logic [7:0] asm_byte;

   assign asm_clr = (st_q != ST_DATA);
   assign asm_en  = (st_q == ST_DATA) && dv_q;

   msgmii_rxnbl_asm u_nbl_asm (
      .rx_clki    (rx_clki),
      .rx_clkirst (rx_clkirst),
      .rxcen      (rxcen),
      .speed      (speed_q),
      .clr        (asm_clr),
      .en         (asm_en),
      .rxd        (rxd_q),
      .byte_o     (asm_byte),
      .byte_done  (asm_done),
      .nbl_pend   (asm_pend)
   );

   // Frame FSM: one byte is held back so the last one can carry eof.
   always_comb begin
      rxd_d      = rxd;
      dv_d       = rx_dv;
      er_d       = rx_er;
      dv_prev_d  = dv_q;
      st_d       = st_q;
      speed_d    = speed_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      sof_pend_d = sof_pend_q;
      err_d      = err_q;
      data_d     = data_q;
      vld_d      = 1'b0;
      sof_d      = 1'b0;
      eof_d      = 1'b0;
      ferr_d     = 1'b0;
      drbl_d     = 1'b0;
      drop_d     = 1'b0;
`ifdef MSGMII_RXSFD_PREMCHK_EN
      pcnt_d     = pcnt_q;
`endif
      unique case (st_q)
         ST_IDLE: begin
            if (dv_q && !dv_prev_q) begin
               st_d       = ST_PRE;
               speed_d    = msgmii_speed;
               hold_vld_d = 1'b0;
               sof_pend_d = 1'b1;
               err_d      = 1'b0;
`ifdef MSGMII_RXSFD_PREMCHK_EN
               pcnt_d     = 5'd1;
               if (!is_sym(msgmii_speed, rxd_q, PRE_BYTE, PRE_NBL)) begin
                  st_d   = ST_DROP;
                  drop_d = 1'b1;
               end
`endif
            end
         end
         ST_PRE: begin
            if (!dv_q) begin
               st_d   = ST_IDLE;
               drop_d = 1'b1;
            end else if (er_q) begin
               st_d   = ST_DROP;
               drop_d = 1'b1;
            end else if (is_sym(speed_q, rxd_q, SFD_BYTE, SFD_NBL)) begin
               st_d = ST_DATA;
            end
`ifdef MSGMII_RXSFD_PREMCHK_EN
            else if (!is_sym(speed_q, rxd_q, PRE_BYTE, PRE_NBL)
                     || pcnt_q >= pre_max) begin
               st_d   = ST_DROP;
               drop_d = 1'b1;
            end else if (pcnt_q != 5'h1f) begin
               pcnt_d = pcnt_q + 5'd1;
            end
`endif
         end
         ST_DATA: begin
            if (dv_q) begin
               if (er_q) begin
                  err_d = 1'b1;
               end
               if (asm_done) begin
                  if (hold_vld_q) begin
                     data_d     = hold_q;
                     vld_d      = 1'b1;
                     sof_d      = sof_pend_q;
                     sof_pend_d = 1'b0;
                  end
                  hold_d     = asm_byte;
                  hold_vld_d = 1'b1;
               end
            end else begin
               st_d = ST_IDLE;
               if (hold_vld_q) begin
                  data_d     = hold_q;
                  vld_d      = 1'b1;
                  sof_d      = sof_pend_q;
                  eof_d      = 1'b1;
                  ferr_d     = err_q | asm_pend;
                  drbl_d     = asm_pend;
                  hold_vld_d = 1'b0;
                  sof_pend_d = 1'b0;
               end else begin
                  drop_d = 1'b1;
               end
            end
         end
         ST_DROP: begin
            if (!dv_q) begin
               st_d = ST_IDLE;
            end
         end
         default: begin
            st_d = ST_IDLE;
         end
      endcase
   end

   // Input capture, FSM state and registered outputs; held while rxcen=0.
   // dv history resets high so rx_dv already asserted at release is not a rise.
   always_ff @(posedge rx_clki or posedge rx_clkirst) begin
      if (rx_clkirst) begin
         rxd_q      <= 8'h00;
         dv_q       <= 1'b1;
         dv_prev_q  <= 1'b1;
         er_q       <= 1'b0;
         st_q       <= ST_IDLE;
         speed_q    <= SPEED_10;
         hold_q     <= 8'h00;
         hold_vld_q <= 1'b0;
         sof_pend_q <= 1'b0;
         err_q      <= 1'b0;
         data_q     <= 8'h00;
         vld_q      <= 1'b0;
         sof_q      <= 1'b0;
         eof_q      <= 1'b0;
         ferr_q     <= 1'b0;
         drbl_q     <= 1'b0;
         drop_q     <= 1'b0;
`ifdef MSGMII_RXSFD_PREMCHK_EN
         pcnt_q     <= 5'd0;
`endif
      end else if (rxcen) begin
         rxd_q      <= rxd_d;
         dv_q       <= dv_d;
         dv_prev_q  <= dv_prev_d;
         er_q       <= er_d;
         st_q       <= st_d;
         speed_q    <= speed_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         sof_pend_q <= sof_pend_d;
         err_q      <= err_d;
         data_q     <= data_d;
         vld_q      <= vld_d;
         sof_q      <= sof_d;
         eof_q      <= eof_d;
         ferr_q     <= ferr_d;
         drbl_q     <= drbl_d;
         drop_q     <= drop_d;
`ifdef MSGMII_RXSFD_PREMCHK_EN
         pcnt_q     <= pcnt_d;
`endif
      end
   end

   assign frm_data = data_q;
   assign frm_vld  = vld_q;
   assign frm_sof  = sof_q;
   assign frm_eof  = eof_q;
   assign frm_err  = ferr_q;
   assign frm_drbl = drbl_q;
   assign frm_drop = drop_q;

endmodule

// File: tb/tb_msgmii_rxsfd_align.sv
// tb_msgmii_rxsfd_align: directed frames at GMII/MII speeds with
// hand-built expected byte streams, flags and latencies.
module tb_msgmii_rxsfd_align;

   logic       rx_clki = 1'b0;
   logic       rx_clkirst = 1'b1;
   logic       rxcen = 1'b1;
   logic [1:0] msgmii_speed = 2'b10;
   logic [7:0] rxd = 8'h00;
   logic       rx_dv = 1'b0;
   logic       rx_er = 1'b0;
   logic [7:0] frm_data;
   logic       frm_vld, frm_sof, frm_eof, frm_err, frm_drbl, frm_drop;

   msgmii_rxsfd_align dut (
      .rx_clki      (rx_clki),
      .rx_clkirst   (rx_clkirst),
      .rxcen        (rxcen),
      .msgmii_speed (msgmii_speed),
      .rxd          (rxd),
      .rx_dv        (rx_dv),
      .rx_er        (rx_er),
      .frm_data     (frm_data),
      .frm_vld      (frm_vld),
      .frm_sof      (frm_sof),
      .frm_eof      (frm_eof),
      .frm_err      (frm_err),
      .frm_drbl     (frm_drbl),
      .frm_drop     (frm_drop)
   );

   always #5 rx_clki = ~rx_clki;

   int n_chk = 0;
   int n_err = 0;
   int cen_div = 1;
   int cen_ph = 0;
   int ecnt = 0;
   logic cen_seen = 1'b0;
   int t_in, t_nxt, t_dv0, t16;

   logic [7:0] tx_q[$];
   logic [7:0] rq_d[$];
   logic [3:0] rq_f[$];
   int         rq_e[$];
   int         dq_e[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge rx_clki) begin
      cen_ph = (cen_ph + 1 >= cen_div) ? 0 : cen_ph + 1;
      rxcen  = (cen_ph == 0);
   end

   always @(posedge rx_clki) begin
      cen_seen <= rxcen;
      if (rxcen) ecnt <= ecnt + 1;
   end

   always @(negedge rx_clki) begin
      if (cen_seen) begin
         if (frm_vld) begin
            rq_d.push_back(frm_data);
            rq_f.push_back({frm_sof, frm_eof, frm_err, frm_drbl});
            rq_e.push_back(ecnt);
         end
         if (frm_drop) dq_e.push_back(ecnt);
      end
   end

   task automatic sym(input logic [7:0] d, input logic dv, input logic er);
      int w;
      @(negedge rx_clki);
      rxd = d;
      rx_dv = dv;
      rx_er = er;
      w = 0;
      do begin
         @(posedge rx_clki);
         w++;
      end while (!rxcen && w < 50);
      #1;
      if (w >= 50) chk("cen_wait", w, 0);
      t_in = ecnt;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) sym(8'h00, 1'b0, 1'b0);
   endtask

   task automatic clr_q();
      rq_d.delete();
      rq_f.delete();
      rq_e.delete();
      dq_e.delete();
   endtask

   function automatic int rec_e(input int i);
      return (i < rq_e.size()) ? rq_e[i] : -1;
   endfunction

   function automatic logic [7:0] rec_d(input int i);
      return (i < rq_d.size()) ? rq_d[i] : 8'hEE;
   endfunction

   function automatic logic [3:0] rec_f(input int i);
      return (i < rq_f.size()) ? rq_f[i] : 4'hF;
   endfunction

   task automatic send_frame(input logic gm, input int npre, input int er_idx,
                             input logic extra, input int ngap);
      t_nxt = -1;
      for (int i = 0; i < npre; i++) sym(gm ? 8'h55 : 8'h05, 1'b1, 1'b0);
      sym(gm ? 8'hD5 : 8'h0D, 1'b1, 1'b0);
      for (int i = 0; i < tx_q.size(); i++) begin
         if (gm) begin
            sym(tx_q[i], 1'b1, i == er_idx);
         end else begin
            sym({4'h0, tx_q[i][3:0]}, 1'b1, i == er_idx);
            sym({4'h0, tx_q[i][7:4]}, 1'b1, 1'b0);
         end
         if (i == 1) t_nxt = t_in;
      end
      if (extra) sym(8'h07, 1'b1, 1'b0);
      sym(8'h00, 1'b0, 1'b0);
      t_dv0 = t_in;
      idle(ngap);
   endtask

   task automatic check_frame(input string tag, input logic ferr,
                              input logic fdrbl);
      int n;
      n = tx_q.size();
      chk({tag, "_n"}, rq_d.size(), n);
      for (int i = 0; i < n && i < rq_d.size(); i++) begin
         chk({tag, "_d"}, rq_d[i], tx_q[i]);
         chk({tag, "_f"}, rq_f[i],
             {i == 0, i == n - 1, (i == n - 1) && ferr, (i == n - 1) && fdrbl});
      end
      chk({tag, "_drop"}, dq_e.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge rx_clki);
      chk("rst_out", {frm_data, frm_vld, frm_sof, frm_eof,
                      frm_err, frm_drbl, frm_drop}, 0);
      rx_clkirst = 1'b0;
      idle(3);
      chk("rst_idle", {frm_vld, frm_drop}, 0);

      // GMII 64-byte frame
      clr_q();
      tx_q.delete();
      for (int i = 1; i <= 64; i++) tx_q.push_back(8'(i));
      msgmii_speed = 2'b10;
      send_frame(1'b1, 7, -1, 1'b0, 4);
      check_frame("gmii", 1'b0, 1'b0);
      chk("gmii_lat_sof", rec_e(0), t_nxt + 1);
      chk("gmii_lat_eof", rec_e(63), t_dv0 + 1);

      // MII 100 Mb/s, rxcen every cycle
      clr_q();
      tx_q = '{8'hA5, 8'hC3};
      msgmii_speed = 2'b01;
      send_frame(1'b0, 15, -1, 1'b0, 4);
      check_frame("mii100", 1'b0, 1'b0);
      chk("mii100_lat_sof", rec_e(0), t_nxt + 1);
      chk("mii100_lat_eof", rec_e(1), t_dv0 + 1);

      // MII 10 Mb/s, rxcen 1-in-10
      clr_q();
      msgmii_speed = 2'b00;
      cen_div = 10;
      send_frame(1'b0, 15, -1, 1'b0, 4);
      check_frame("mii10", 1'b0, 1'b0);
      chk("mii10_lat_eof", rec_e(1), t_dv0 + 1);
      cen_div = 1;
      idle(2);

      // MII dribble nibble
      clr_q();
      tx_q = '{8'h12, 8'h34, 8'h56};
      msgmii_speed = 2'b01;
      send_frame(1'b0, 7, -1, 1'b1, 4);
      check_frame("drbl", 1'b1, 1'b1);

      // GMII rx_er on data byte 10 of 60
      clr_q();
      tx_q.delete();
      for (int i = 1; i <= 60; i++) tx_q.push_back(8'(i));
      msgmii_speed = 2'b10;
      send_frame(1'b1, 7, 9, 1'b0, 4);
      check_frame("rxer", 1'b1, 1'b0);

      // 20 preamble bytes, no SFD
      clr_q();
      for (int i = 0; i < 20; i++) begin
         sym(8'h55, 1'b1, 1'b0);
         if (i == 15) t16 = t_in;
      end
      sym(8'h00, 1'b0, 1'b0);
      t_dv0 = t_in;
      idle(4);
      chk("nosfd_vld", rq_d.size(), 0);
      chk("nosfd_ndrop", dq_e.size(), 1);
`ifdef MSGMII_RXSFD_PREMCHK_EN
      chk("nosfd_drop_t", (dq_e.size() > 0) ? dq_e[0] : -1, t16 + 1);
`else
      chk("nosfd_drop_t", (dq_e.size() > 0) ? dq_e[0] : -1, t_dv0 + 1);
`endif

      // back-to-back frames with a single rx_dv=0 gap
      clr_q();
      tx_q = '{8'hAA, 8'hBB};
      send_frame(1'b1, 3, -1, 1'b0, 0);
      tx_q = '{8'hCC, 8'hDD};
      send_frame(1'b1, 3, -1, 1'b0, 4);
      chk("b2b_n", rq_d.size(), 4);
      chk("b2b_d", {rec_d(0), rec_d(1), rec_d(2), rec_d(3)}, 32'hAABBCCDD);
      chk("b2b_f", {rec_f(0), rec_f(1), rec_f(2), rec_f(3)}, 16'h8484);

      // reset mid-frame, released with rx_dv high
      clr_q();
      for (int i = 0; i < 7; i++) sym(8'h55, 1'b1, 1'b0);
      sym(8'hD5, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) sym(8'(i), 1'b1, 1'b0);
      chk("mid_pre_vld", frm_vld, 1'b1);
      rx_clkirst = 1'b1;
      #1;
      chk("mid_rst_out", {frm_data, frm_vld, frm_sof, frm_eof,
                          frm_err, frm_drbl, frm_drop}, 0);
      clr_q();
      sym(8'h06, 1'b1, 1'b0);
      sym(8'h07, 1'b1, 1'b0);
      rx_clkirst = 1'b0;
      for (int i = 8; i <= 12; i++) sym(8'(i), 1'b1, 1'b0);
      sym(8'h00, 1'b0, 1'b0);
      idle(4);
      chk("mid_no_vld", rq_d.size(), 0);
      chk("mid_no_drop", dq_e.size(), 0);
      clr_q();
      tx_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      send_frame(1'b1, 7, -1, 1'b0, 4);
      check_frame("after_rst", 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
